// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared encodings for the two-master memory arbiter: sequencer
//               states, master identifiers and access direction.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Master identifiers
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    // Access direction
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Width of the access latency counter
    localparam int CNT_W = 4;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles both master req/ack ports, the shared memory port and
//               the arbiter status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Master 0 (cpu)
    logic              m0_req;
    logic              m0_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    // Master 1 (dma / debug loader)
    logic              m1_req;
    logic              m1_rw;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    // Memory port
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              owner;

    // Arbiter side
    modport slave (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    // Masters / memory side
    modport master (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational round-robin arbiter. A single request
//               is granted directly; on a tie the master that did not own the
//               last transaction wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_bus_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last_owner,
    output logic            gnt_valid,
    output logic            gnt_id
);

    // Grant selection: direct on a single request, alternate on a tie
    always_comb begin
        gnt_valid = |req;
        gnt_id    = MST_CPU;
        if (req == 2'b11) begin
            gnt_id = ~last_owner;
        end else if (req[1]) begin
            gnt_id = MST_AUX;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous memory port between two masters.
//               A three-state sequencer (IDLE/ACCESS/RESP) holds each granted
//               access on the memory port for MEM_LATENCY cycles, then pulses
//               the owner's ack for one cycle with registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    // The 4-bit counter can only express latencies of 1..15
    if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_latency_check
        $error("mem_arbiter: MEM_LATENCY=%0d is outside 1..15", MEM_LATENCY);
    end

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_grant;
    logic              w_last_access;
    logic              w_mem_en;
    logic              w_busy;
    logic              w_m0_ack;
    logic              w_m1_ack;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_owner (r_last_owner),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    // Arbitration only takes effect in IDLE; RESP never grants
    assign w_grant       = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == CNT_W'(1));

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_mem_en    = 1'b0;
        w_busy      = 1'b1;
        w_m0_ack    = 1'b0;
        w_m1_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_gnt_valid) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_en = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_m0_ack    = (r_owner == MST_CPU);
                w_m1_ack    = (r_owner == MST_AUX);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant capture: memory request registers, ownership and latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_owner      <= MST_CPU;
            r_last_owner <= MST_AUX;
            r_mem_rw     <= RW_READ;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (w_grant) begin
            r_cnt        <= c_cnt_load;
            r_owner      <= w_gnt_id;
            r_last_owner <= w_gnt_id;
            r_mem_rw     <= w_gnt_id ? bus.m1_rw    : bus.m0_rw;
            r_mem_addr   <= w_gnt_id ? bus.m1_addr  : bus.m0_addr;
            r_mem_wdata  <= w_gnt_id ? bus.m1_wdata : bus.m0_wdata;
        end else if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Read data capture into the owner's register on the last ACCESS edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (w_last_access && (r_mem_rw == RW_READ)) begin
            if (r_owner == MST_CPU) begin
                r_m0_rdata <= bus.mem_rdata;
            end else begin
                r_m1_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.m0_ack    = w_m0_ack;
    assign bus.m1_ack    = w_m1_ack;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.busy      = w_busy;
    assign bus.owner     = r_owner;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter with one instance at
//               MEM_LATENCY=1 and one at MEM_LATENCY=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_sel;
    logic [31:0] mem_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if3)
    );

    // Memory models: fixed value or address-derived data
    assign if1.mem_rdata = mem_sel ? (if1.mem_addr + 32'h1000_0000) : mem_val;
    assign if3.mem_rdata = if3.mem_addr + 32'h1000_0000;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        mem_sel = 1'b0;
        mem_val = 32'h0;
        if1.m0_req = 1'b0; if1.m0_rw = 1'b0; if1.m0_addr = '0; if1.m0_wdata = '0;
        if1.m1_req = 1'b0; if1.m1_rw = 1'b0; if1.m1_addr = '0; if1.m1_wdata = '0;
        if3.m0_req = 1'b0; if3.m0_rw = 1'b0; if3.m0_addr = '0; if3.m0_wdata = '0;
        if3.m1_req = 1'b0; if3.m1_rw = 1'b0; if3.m1_addr = '0; if3.m1_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // ---- Reset release, no requests, 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            tick();
            check1("idle_busy",   if1.busy,   1'b0);
            check1("idle_mem_en", if1.mem_en, 1'b0);
            check1("idle_m0_ack", if1.m0_ack, 1'b0);
            check1("idle_m1_ack", if1.m1_ack, 1'b0);
            check1("idle_owner",  if1.owner,  1'b0);
        end
        check1("rst_mem_rw",    if1.mem_rw,    1'b0);
        check ("rst_mem_addr",  if1.mem_addr,  32'h0);
        check ("rst_mem_wdata", if1.mem_wdata, 32'h0);
        check ("rst_m0_rdata",  if1.m0_rdata,  32'h0);
        check ("rst_m1_rdata",  if1.m1_rdata,  32'h0);
        check1("rst3_busy",     if3.busy,      1'b0);
        check1("rst3_mem_en",   if3.mem_en,    1'b0);

        // ---- L=1: m0 read 0x100 returns 0xDEADBEEF ----
        mem_val     = 32'hDEAD_BEEF;
        if1.m0_addr = 32'h100;
        if1.m0_rw   = 1'b0;
        if1.m0_req  = 1'b1;
        tick();
        check1("rd_c1_mem_en", if1.mem_en,   1'b1);
        check ("rd_c1_addr",   if1.mem_addr, 32'h100);
        check1("rd_c1_busy",   if1.busy,     1'b1);
        check1("rd_c1_ack",    if1.m0_ack,   1'b0);
        tick();
        check1("rd_c2_mem_en", if1.mem_en,   1'b0);
        check1("rd_c2_ack",    if1.m0_ack,   1'b1);
        check1("rd_c2_m1_ack", if1.m1_ack,   1'b0);
        check ("rd_c2_rdata",  if1.m0_rdata, 32'hDEAD_BEEF);
        check ("rd_c2_m1_rd",  if1.m1_rdata, 32'h0);
        if1.m0_req = 1'b0;
        tick();
        check1("rd_c3_ack",    if1.m0_ack,   1'b0);
        check1("rd_c3_busy",   if1.busy,     1'b0);
        check ("rd_c3_hold",   if1.m0_rdata, 32'hDEAD_BEEF);
        tick();
        check1("rd_c4_mem_en", if1.mem_en,   1'b0);

        // ---- Both masters requesting continuously: alternation ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_sel     = 1'b1;
        if1.m0_addr = 32'h10;
        if1.m1_addr = 32'h20;
        if1.m0_rw   = 1'b0;
        if1.m1_rw   = 1'b0;
        if1.m0_req  = 1'b1;
        if1.m1_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_o;
            exp_o = i[0];
            tick();
            check1("rr_owner",  if1.owner,  exp_o);
            check1("rr_mem_en", if1.mem_en, 1'b1);
            check ("rr_addr",   if1.mem_addr, exp_o ? 32'h20 : 32'h10);
            tick();
            check1("rr_ack_own",   exp_o ? if1.m1_ack : if1.m0_ack, 1'b1);
            check1("rr_ack_other", exp_o ? if1.m0_ack : if1.m1_ack, 1'b0);
            check ("rr_rdata", exp_o ? if1.m1_rdata : if1.m0_rdata,
                   exp_o ? 32'h1000_0020 : 32'h1000_0010);
            if (i == 3) begin
                if1.m0_req = 1'b0;
                if1.m1_req = 1'b0;
            end
            tick();
            check1("rr_idle_busy", if1.busy,   1'b0);
            check1("rr_idle_ack0", if1.m0_ack, 1'b0);
            check1("rr_idle_ack1", if1.m1_ack, 1'b0);
        end

        // ---- L=3: m1 read 0x44 to preload m1_rdata, then write 0x55AA to 0x40 ----
        if3.m1_addr = 32'h44;
        if3.m1_rw   = 1'b0;
        if3.m1_req  = 1'b1;
        tick();
        tick();
        tick();
        check1("l3rd_c3_ack", if3.m1_ack, 1'b0);
        tick();
        check1("l3rd_ack",   if3.m1_ack,   1'b1);
        check ("l3rd_rdata", if3.m1_rdata, 32'h1000_0044);
        if3.m1_req = 1'b0;
        tick();
        if3.m1_addr  = 32'h40;
        if3.m1_wdata = 32'h55AA;
        if3.m1_rw    = 1'b1;
        if3.m1_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("wr_mem_en", if3.mem_en,    1'b1);
            check1("wr_mem_rw", if3.mem_rw,    1'b1);
            check ("wr_addr",   if3.mem_addr,  32'h40);
            check ("wr_wdata",  if3.mem_wdata, 32'h55AA);
            check1("wr_ack",    if3.m1_ack,    1'b0);
            check1("wr_owner",  if3.owner,     1'b1);
        end
        tick();
        check1("wr_c4_ack",    if3.m1_ack,   1'b1);
        check1("wr_c4_mem_en", if3.mem_en,   1'b0);
        check ("wr_m1_rdata",  if3.m1_rdata, 32'h1000_0044);
        check ("wr_m0_rdata",  if3.m0_rdata, 32'h0);
        if3.m1_req = 1'b0;
        tick();
        check1("wr_c5_busy", if3.busy,   1'b0);
        check1("wr_c5_ack",  if3.m1_ack, 1'b0);

        // ---- Reset during ACCESS, then tie after release ----
        if1.m0_addr = 32'h100;
        if1.m0_rw   = 1'b0;
        if1.m0_req  = 1'b1;
        tick();
        check1("rst_mid_mem_en", if1.mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rst_mid_en_off", if1.mem_en, 1'b0);
        check1("rst_mid_busy",   if1.busy,   1'b0);
        check1("rst_mid_ack",    if1.m0_ack, 1'b0);
        tick();
        check1("rst_hold_ack",   if1.m0_ack, 1'b0);
        check1("rst_hold_owner", if1.owner,  1'b0);
        rst_n = 1'b1;
        if1.m1_req = 1'b1;
        tick();
        check1("rst_tie_owner",  if1.owner,  1'b0);
        check1("rst_tie_mem_en", if1.mem_en, 1'b1);
        tick();
        check1("rst_tie_ack0", if1.m0_ack,   1'b1);
        check ("rst_tie_rd0",  if1.m0_rdata, 32'h1000_0100);
        if1.m0_req = 1'b0;
        tick();
        check1("rst_tie_idle", if1.busy, 1'b0);
        tick();
        check1("rst_tie_owner1", if1.owner, 1'b1);
        tick();
        check1("rst_tie_ack1", if1.m1_ack,   1'b1);
        check ("rst_tie_rd1",  if1.m1_rdata, 32'h1000_0020);
        if1.m1_req = 1'b0;
        tick();

        // ---- m0 drops req during ACCESS with m1 pending ----
        if1.m0_req = 1'b1;
        if1.m1_req = 1'b1;
        tick();
        check1("drop_owner0", if1.owner,  1'b0);
        check1("drop_en",     if1.mem_en, 1'b1);
        if1.m0_req = 1'b0;
        tick();
        check1("drop_ack0",   if1.m0_ack, 1'b1);
        check1("drop_ack1_n", if1.m1_ack, 1'b0);
        tick();
        check1("drop_idle_ack0", if1.m0_ack, 1'b0);
        check1("drop_idle_busy", if1.busy,   1'b0);
        tick();
        check1("drop_owner1",  if1.owner,  1'b1);
        check1("drop_en1",     if1.mem_en, 1'b1);
        check1("drop_no_ack0", if1.m0_ack, 1'b0);
        tick();
        check1("drop_ack1",    if1.m1_ack, 1'b1);
        check1("drop_no_ack0b", if1.m0_ack, 1'b0);
        if1.m1_req = 1'b0;
        tick();
        check1("drop_end_busy", if1.busy,   1'b0);
        check1("drop_end_ack1", if1.m1_ack, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one synchronous memory port between two bus masters: port 0 (cpu) and port 1 (dma/debug loader). It uses a req/ack handshake with round-robin fairness on ties. A three-state sequencer presents each granted access to memory for MEM_LATENCY cycles, then returns read data with a one-cycle ack pulse. It sits between `cpu` (plus a secondary master) and the RAM/ROM decode.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from mem_en/address valid to mem_rdata valid; legal 1..15
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- m0_req  in  1  master 0 requests an access; held until m0_ack
- m0_rw  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  access address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  registered read data, valid when m0_ack=1, held afterwards
- m1_req, m1_rw, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*
- mem_en  out  1  memory access active
- mem_rw  out  1  1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  master of the current or last transaction

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - With no req, stay in IDLE.
  - With exactly one req, grant that master.
  - With both reqs, grant the master that is not last_owner.
  - On grant: latch addr, wdata and rw into the mem_* registers; owner <= grant; last_owner <= grant; cnt <= MEM_LATENCY; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_wdata and mem_rw stay stable.
  - cnt decrements each cycle.
  - When cnt==1 and the access is a read, capture mem_rdata into the owner's rdata register.
  - When cnt==1, go to RESP.
- RESP:
  - mem_en=0; the owner's ack=1 for this cycle only.
  - Always go to IDLE. Arbitration never happens in RESP.
- Reads:
  - Only the owner's rdata updates.
  - The other master's rdata is never disturbed.
- Writes:
  - No rdata update.
  - mem_rw=1 for every ACCESS cycle. Memory must tolerate the repeated (idempotent) write.
- req dropped during ACCESS: the transaction completes and ack still pulses. Masters must not change addr/wdata/rw before ack; the arbiter does not sample them after the grant.
- req dropped before grant: no effect.
- Reset asserted mid-transaction:
  - Immediate return to IDLE, with no ack.
  - A later retry is the master's responsibility.
- cnt is 4 bits.
- MEM_LATENCY outside 1..15 is a parameter error; flag it in simulation with $error.

## Timing
- Reset values: state=IDLE, last_owner=1 (so m0 wins the first tie), owner=0, busy=0, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
- Cycle numbering for one transaction:
  - cycle 0: req sampled in IDLE.
  - cycles 1..MEM_LATENCY: ACCESS, mem_en=1.
  - cycle MEM_LATENCY+1: RESP, ack=1, rdata valid.
  - cycle MEM_LATENCY+2: IDLE, next grant possible.
- Latency req->ack = MEM_LATENCY+1 cycles.
- Peak throughput: one transaction per MEM_LATENCY+2 cycles.
- A master holding req through ack gets re-arbitrated in the IDLE cycle after RESP. With the other master pending, it loses that tie.
- mem_rdata is sampled on the clock edge ending the last ACCESS cycle.
- ack is never high for more than one consecutive cycle.
- m0_ack and m1_ack are never high in the same cycle.

## Structure
- Shared package mem_bus_pkg:
  - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - MST_CPU=1'b0, MST_AUX=1'b1
  - RW_READ=1'b0, RW_WRITE=1'b1
- Sub-module rr_arb2:
  - inputs: req[1:0], last_owner
  - outputs: gnt_valid, gnt_id
  - purely combinational; reused by future multi-port peripherals.
- mem_arbiter holds the FSM, cnt, the mem_* registers and the per-master rdata registers.

## Test plan
- Reset release, no reqs, 10 cycles -> all outputs 0, busy=0.
- MEM_LATENCY=1: m0 read addr 0x100, memory returns 0xDEADBEEF -> mem_en high in cycle 1 only, m0_ack in cycle 2 with m0_rdata=0xDEADBEEF, m1_rdata stays 0.
- m0 and m1 both hold req continuously, reads of 0x10 and 0x20 -> grants alternate m0,m1,m0,m1; one ack every 3 cycles; owner toggles.
- MEM_LATENCY=3: m1 write 0x55AA to 0x40 -> mem_en=mem_rw=1 with mem_addr=0x40 and mem_wdata=0x55AA for 3 cycles; m1_ack in cycle 4; m1_rdata unchanged.
- m0 read granted, reset pulled low in ACCESS cycle 1 -> mem_en=0 and busy=0 immediately, no ack; after release, m0 and m1 tie -> m0 granted first.
- m0 drops req in cycle 1 of its ACCESS -> m0_ack still pulses exactly once; a pending m1 is granted in the following IDLE cycle.
